mem_bist_ctrl: RTL and testbench

- Built-in self-test sequencer sitting directly upstream of the 8x8 single-port RAM. It drives the RAM's we/addr/wrdata and consumes its rddata.
- On a start pulse it runs a 4-element March test (a March C- subset) over every address and compares each read against the expected pattern.
- It reports done, pass/fail, the first failing address and a mismatch count.
- The RAM's own rst is not driven by this block. The system holds it low during a test.

---
 rtl/mem_bist_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// ----------------------------------------------------------------------------
// mem_bist_ctrl
//   Built-in self-test sequencer for a small single-port RAM with registered
//   read data. A start pulse runs a four-element March sequence:
//     M0: ascending  w(P)
//     M1: ascending  r(P),  w(~P)
//     M2: descending r(~P), w(P)
//     M3: ascending  r(P)
//   A DRAIN cycle then compares the last M3 read. Each read is checked one
//   cycle later against the expected pattern.
//
// Ports
//   clk         rising-edge clock, shared with the RAM
//   rst         asynchronous active-high reset
//   start       single-cycle test request (accepted in IDLE or DONE only)
//   mem_we      RAM write enable
//   mem_addr    RAM address
//   mem_wrdata  RAM write data
//   mem_rddata  RAM registered read data (valid the cycle after a read)
//   busy        test in progress (M0 through DRAIN)
//   done        test complete, held until next accepted start or reset
//   pass        done with zero mismatches
//   fail_addr   address of the first mismatch of the run, 0 if none
//   fail_count  number of mismatches, saturating at all-ones
// ----------------------------------------------------------------------------
module mem_bist_ctrl #(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wrdata,
  input  logic [DATA_WIDTH-1:0] mem_rddata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  // Sequencer state. r_phase selects read (0) or write (1) inside M1/M2.
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_phase;

  // Compare pipeline: what the RAM should return in the next cycle.
  logic                    r_exp_valid;
  logic [DATA_WIDTH-1:0]   r_exp_data;
  logic [ADDR_WIDTH-1:0]   r_exp_addr;

  // Results.
  logic [ADDR_WIDTH+1:0]   r_fail_count;
  logic [ADDR_WIDTH-1:0]   r_fail_addr;

  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic                    w_phase_nxt;
  logic                    w_accept;
  logic                    w_read;
  logic [DATA_WIDTH-1:0]   w_exp_data_nxt;
  logic                    w_mismatch;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mismatch = r_exp_valid && (mem_rddata != r_exp_data);

  // A read happens on the first cycle of each M1/M2 pair and every M3 cycle.
  assign w_read = (((r_state == S_M1) || (r_state == S_M2)) && !r_phase) ||
                  (r_state == S_M3);
  assign w_exp_data_nxt = (r_state == S_M2) ? ~PATTERN : PATTERN;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, address and phase
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = S_M0;
          w_addr_nxt  = '0;
          w_phase_nxt = 1'b0;
        end
      end

      S_M0: begin
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = S_M1;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
        end
      end

      S_M1: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (r_addr == ADDR_LAST) begin
            // M2 runs descending, so it starts where M1 ended.
            w_state_nxt = S_M2;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
          end
        end
      end

      S_M2: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (r_addr == ADDR_ZERO) begin
            w_state_nxt = S_M3;
          end else begin
            w_addr_nxt  = r_addr - 1'b1;
          end
        end
      end

      S_M3: begin
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = S_DRAIN;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
        end
      end

      S_DRAIN: w_state_nxt = S_DONE;

      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
        w_phase_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Compare pipeline and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_valid  <= 1'b0;
      r_exp_data   <= '0;
      r_exp_addr   <= '0;
      r_fail_count <= '0;
      r_fail_addr  <= '0;
    end else if (w_accept) begin
      r_exp_valid  <= 1'b0;
      r_fail_count <= '0;
      r_fail_addr  <= '0;
    end else begin
      r_exp_valid <= w_read;
      r_exp_data  <= w_exp_data_nxt;
      r_exp_addr  <= r_addr;
      if (w_mismatch) begin
        // The count never returns to zero within a run, so zero marks the
        // first hit.
        if (r_fail_count == '0) begin
          r_fail_addr <= r_exp_addr;
        end
        if (r_fail_count != '1) begin
          r_fail_count <= r_fail_count + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we     = 1'b0;
    mem_wrdata = '0;
    case (r_state)
      S_M0: begin
        mem_we     = 1'b1;
        mem_wrdata = PATTERN;
      end
      S_M1: begin
        mem_we     = r_phase;
        mem_wrdata = r_phase ? ~PATTERN : '0;
      end
      S_M2: begin
        mem_we     = r_phase;
        mem_wrdata = r_phase ? PATTERN : '0;
      end
      default: ;
    endcase
  end

  assign mem_addr   = r_addr;
  assign busy       = (r_state == S_M0) || (r_state == S_M1) || (r_state == S_M2) ||
                      (r_state == S_M3) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_fail_count == '0);
  assign fail_addr  = r_fail_addr;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_bist_ctrl
//   Directed bench for mem_bist_ctrl with a behavioural 8x8 RAM that can
//   have per-address stuck bits (read value = (stored & and_mask) | or_mask).
// ----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_wrdata;
  logic [7:0] mem_rddata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_addr;
  logic [4:0] fail_count;

  int n_cmp;
  int n_err;

  mem_bist_ctrl #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .PATTERN   (8'h55)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wrdata(mem_wrdata),
    .mem_rddata(mem_rddata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with fault injection.
  logic [7:0] ram      [8];
  logic [7:0] and_mask [8];
  logic [7:0] or_mask  [8];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wrdata;
    else        mem_rddata    <= (ram[mem_addr] & and_mask[mem_addr]) | or_mask[mem_addr];
  end

  // Per-cycle trace of the last run (index 0 = first busy cycle).
  logic       we_log   [64];
  logic [2:0] addr_log [64];
  logic [7:0] wd_log   [64];
  logic       first_done;
  logic [4:0] first_fc;
  logic [2:0] first_fa;

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) begin
      and_mask[i] = 8'hFF;
      or_mask[i]  = 8'h00;
    end
  endtask

  // Pulse start, then follow the run until busy drops (bounded). Optionally
  // pulses start again at busy index mid_idx. reads excludes the DRAIN cycle.
  task automatic run_bist(input int mid_idx, output int cycles,
                          output int writes, output int reads);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    writes = 0;
    reads  = 0;
    first_done = done;
    first_fc   = fail_count;
    first_fa   = fail_addr;
    while (busy === 1'b1 && cycles < 200) begin
      start = (cycles == mid_idx);
      if (cycles < 64) begin
        we_log[cycles]   = mem_we;
        addr_log[cycles] = mem_addr;
        wd_log[cycles]   = mem_wrdata;
      end
      if (mem_we) writes++;
      else        reads++;
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    if (reads > 0) reads--;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wrdata, busy, done, pass, fail_addr, fail_count} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 000000",
               {mem_we, mem_addr, mem_wrdata, busy, done, pass, fail_addr, fail_count});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    int cyc, wr, rd;
    clear_faults();
    run_bist(-1, cyc, wr, rd);
    n_cmp++; if (cyc !== 49) begin n_err++; $display("FAIL ff_busy_cycles: got %0d required 49", cyc); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ff_done: got %b required 1", done); end
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL ff_pass: got %b required 1", pass); end
    n_cmp++; if (fail_count !== 5'd0) begin n_err++; $display("FAIL ff_fail_count: got %0d required 0", fail_count); end
    n_cmp++; if (wr !== 24) begin n_err++; $display("FAIL ff_writes: got %0d required 24", wr); end
    n_cmp++; if (rd !== 24) begin n_err++; $display("FAIL ff_reads: got %0d required 24", rd); end
    // Spot checks on the access sequence: {we, addr, wrdata}.
    n_cmp++; if ({we_log[0], addr_log[0], wd_log[0]} !== {1'b1, 3'd0, 8'h55})
      begin n_err++; $display("FAIL ff_m0_first: got %h required 055", {we_log[0], addr_log[0], wd_log[0]}); end
    n_cmp++; if ({we_log[7], addr_log[7], wd_log[7]} !== {1'b1, 3'd7, 8'h55})
      begin n_err++; $display("FAIL ff_m0_last: got %h required 755", {we_log[7], addr_log[7], wd_log[7]}); end
    n_cmp++; if ({we_log[8], addr_log[8]} !== {1'b0, 3'd0})
      begin n_err++; $display("FAIL ff_m1_read0: got %h required 0", {we_log[8], addr_log[8]}); end
    n_cmp++; if ({we_log[9], addr_log[9], wd_log[9]} !== {1'b1, 3'd0, 8'hAA})
      begin n_err++; $display("FAIL ff_m1_write0: got %h required 0aa", {we_log[9], addr_log[9], wd_log[9]}); end
    n_cmp++; if ({we_log[24], addr_log[24]} !== {1'b0, 3'd7})
      begin n_err++; $display("FAIL ff_m2_read7: got %h required 7", {we_log[24], addr_log[24]}); end
    n_cmp++; if ({we_log[25], addr_log[25], wd_log[25]} !== {1'b1, 3'd7, 8'h55})
      begin n_err++; $display("FAIL ff_m2_write7: got %h required 755", {we_log[25], addr_log[25], wd_log[25]}); end
    n_cmp++; if ({we_log[39], addr_log[39], wd_log[39]} !== {1'b1, 3'd0, 8'h55})
      begin n_err++; $display("FAIL ff_m2_write0: got %h required 055", {we_log[39], addr_log[39], wd_log[39]}); end
    n_cmp++; if ({we_log[40], addr_log[40]} !== {1'b0, 3'd0})
      begin n_err++; $display("FAIL ff_m3_read0: got %h required 0", {we_log[40], addr_log[40]}); end
    n_cmp++; if (we_log[48] !== 1'b0)
      begin n_err++; $display("FAIL ff_drain_we: got %b required 0", we_log[48]); end
  endtask

  task automatic test_stuck_bit();
    int cyc, wr, rd;
    clear_faults();
    and_mask[5] = 8'hFE;   // bit0 stuck-at-0: 0x55 reads 0x54, 0xAA unaffected
    run_bist(-1, cyc, wr, rd);
    n_cmp++; if (fail_count !== 5'd2) begin n_err++; $display("FAIL sb_fail_count: got %0d required 2", fail_count); end
    n_cmp++; if (fail_addr !== 3'd5) begin n_err++; $display("FAIL sb_fail_addr: got %0d required 5", fail_addr); end
    n_cmp++; if ({done, pass} !== 2'b10) begin n_err++; $display("FAIL sb_done_pass: got %b required 10", {done, pass}); end
  endtask

  task automatic test_stuck_byte();
    int cyc, wr, rd;
    clear_faults();
    and_mask[2] = 8'h00;
    or_mask[2]  = 8'hAA;
    run_bist(-1, cyc, wr, rd);
    n_cmp++; if (fail_count !== 5'd2) begin n_err++; $display("FAIL sy_fail_count: got %0d required 2", fail_count); end
    n_cmp++; if (fail_addr !== 3'd2) begin n_err++; $display("FAIL sy_fail_addr: got %0d required 2", fail_addr); end
  endtask

  task automatic test_two_faults();
    int cyc, wr, rd;
    clear_faults();
    and_mask[2] = 8'h00; or_mask[2] = 8'hAA;
    and_mask[6] = 8'h00; or_mask[6] = 8'hAA;
    run_bist(-1, cyc, wr, rd);
    n_cmp++; if (fail_count !== 5'd4) begin n_err++; $display("FAIL tf_fail_count: got %0d required 4", fail_count); end
    n_cmp++; if (fail_addr !== 3'd2) begin n_err++; $display("FAIL tf_fail_addr: got %0d required 2", fail_addr); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL tf_pass: got %b required 0", pass); end
  endtask

  // Starts from DONE with failing results held, clears faults, and pulses
  // start again mid-run at busy index 10.
  task automatic test_restart_and_ignore();
    int cyc, wr, rd;
    clear_faults();
    run_bist(10, cyc, wr, rd);
    n_cmp++; if ({first_done, first_fc, first_fa} !== 9'h0)
      begin n_err++; $display("FAIL rs_cleared: got %h required 000", {first_done, first_fc, first_fa}); end
    n_cmp++; if (cyc !== 49) begin n_err++; $display("FAIL rs_busy_cycles: got %0d required 49", cyc); end
    n_cmp++; if ({done, pass, fail_count} !== 7'b11_00000)
      begin n_err++; $display("FAIL rs_result: got %b required 1100000", {done, pass, fail_count}); end
  endtask

  task automatic test_async_reset();
    int cyc, wr, rd;
    clear_faults();
    and_mask[3] = 8'h00;   // make results non-zero before the abort
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wrdata, busy, done, pass, fail_addr, fail_count} !== 24'h0) begin
      n_err++;
      $display("FAIL ar_outputs: got %h required 000000",
               {mem_we, mem_addr, mem_wrdata, busy, done, pass, fail_addr, fail_count});
    end
    // start together with reset: reset wins.
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_start_with_rst: got busy %b required 0", busy); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    clear_faults();
    run_bist(-1, cyc, wr, rd);
    n_cmp++; if (cyc !== 49) begin n_err++; $display("FAIL ar_busy_cycles: got %0d required 49", cyc); end
    n_cmp++; if ({done, pass} !== 2'b11) begin n_err++; $display("FAIL ar_done_pass: got %b required 11", {done, pass}); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_stuck_byte();
    test_two_faults();
    test_restart_and_ignore();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
